// File: rtl/isa_pkg.sv
// Shared ISA definitions: opcodes, instruction field positions and the
// entry-encoder state encoding. Imported by both encoder and decoder so the
// word layout lives in exactly one place.
package isa_pkg;

    localparam int unsigned INSTR_W = 16;
    localparam int unsigned FIELD_W = 4;
    localparam int unsigned IMM_W   = 8;
    localparam int unsigned STEP_W  = 2;

    // Opcodes
    localparam logic [FIELD_W-1:0] OP_NOP    = 4'h0;
    localparam logic [FIELD_W-1:0] LD_OPCODE = 4'h1;
    localparam logic [FIELD_W-1:0] OP_ADD    = 4'h2;
    localparam logic [FIELD_W-1:0] OP_SUB    = 4'h3;

    // Field bit positions
    localparam int unsigned OP_MSB     = 15;
    localparam int unsigned OP_LSB     = 12;
    localparam int unsigned RD_IMM_MSB = 11;
    localparam int unsigned RD_IMM_LSB = 8;
    localparam int unsigned RD_REG_MSB = 7;
    localparam int unsigned RD_REG_LSB = 4;
    localparam int unsigned RS_MSB     = 3;
    localparam int unsigned RS_LSB     = 0;
    localparam int unsigned IMM_MSB    = 7;
    localparam int unsigned IMM_LSB    = 0;

    // Encoder entry states; values 0..3 are shown directly on the LEDs
    typedef enum logic [2:0] {
        S_OP   = 3'd0,
        S_RD   = 3'd1,
        S_SRC  = 3'd2,
        S_SEND = 3'd3,
        S_FULL = 3'd4
    } enc_state_t;

    // LED step code: the full state shares code 3 with S_SEND
    function automatic logic [STEP_W-1:0] step_of(input enc_state_t s);
        return (s == S_FULL) ? 2'd3 : s[STEP_W-1:0];
    endfunction

endpackage

// File: rtl/instr_pack.sv
// Combinational instruction packer: {op, rd, rs, imm} -> 16-bit word.
// Immediate format {op, rd, imm} when op is the load opcode, otherwise
// register format {op, 4'h0, rd, rs}.
//   op, rd, rs : 4-bit fields
//   imm        : 8-bit immediate
//   word_c     : packed instruction (combinational)
module instr_pack #(
    parameter logic [3:0] LD_OPCODE = isa_pkg::LD_OPCODE
) (
    input  logic [3:0]  op,
    input  logic [3:0]  rd,
    input  logic [3:0]  rs,
    input  logic [7:0]  imm,
    output logic [15:0] word_c
);
    import isa_pkg::*;

    // Place fields; unused bits of the register format stay zero
    always_comb begin
        word_c = '0;
        word_c[OP_MSB:OP_LSB] = op;
        if (op == LD_OPCODE) begin
            word_c[RD_IMM_MSB:RD_IMM_LSB] = rd;
            word_c[IMM_MSB:IMM_LSB]       = imm;
        end else begin
            word_c[RD_REG_MSB:RD_REG_LSB] = rd;
            word_c[RS_MSB:RS_LSB]         = rs;
        end
    end

endmodule

// File: rtl/instr_encoder.sv
// Instruction-entry encoder: builds instruction words from switches over
// three enter presses and hands each to instruction memory via valid/ready.
//   clk, rst_n     : clock, async active-low reset
//   sw             : switch value captured on enter
//   enter, clear   : single-cycle pulses (clear has priority)
//   instr_out      : assembled word
//   instr_valid    : instr_out/wr_addr valid for write
//   instr_ready    : memory accepts word this cycle
//   wr_addr        : target address
//   mem_full       : last address written, entry blocked until clear
//   step           : LED state code
module instr_encoder #(
    parameter int unsigned ADDR_W    = 4,
    parameter logic [3:0]  LD_OPCODE = isa_pkg::LD_OPCODE
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic [7:0]        sw,
    input  logic              enter,
    input  logic              clear,
    output logic [15:0]       instr_out,
    output logic              instr_valid,
    input  logic              instr_ready,
    output logic [ADDR_W-1:0] wr_addr,
    output logic              mem_full,
    output logic [1:0]        step
);
    import isa_pkg::*;

    enc_state_t        state_q, state_d;
    logic [3:0]        op_q, op_d, rd_q, rd_d, rs_q, rs_d;
    logic [7:0]        imm_q, imm_d;
    logic [15:0]       instr_d, word_c;
    logic              valid_d, full_d;
    logic [ADDR_W-1:0] addr_d;
    logic [1:0]        step_d;

    // Word is packed from the values being latched this cycle
    instr_pack #(.LD_OPCODE(LD_OPCODE)) u_pack (
        .op     (op_q),
        .rd     (rd_q),
        .rs     (rs_d),
        .imm    (imm_d),
        .word_c (word_c)
    );

    // State register
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state_q <= S_OP;
        else        state_q <= state_d;
    end

    // Next-state and next-output logic
    always_comb begin
        state_d = state_q;
        op_d    = op_q;
        rd_d    = rd_q;
        rs_d    = rs_q;
        imm_d   = imm_q;
        instr_d = instr_out;
        valid_d = 1'b0;
        addr_d  = wr_addr;
        full_d  = mem_full;
        unique case (state_q)
            S_OP, S_RD, S_SRC: begin
                if (clear) begin
                    state_d = S_OP;
                    op_d    = '0;
                    rd_d    = '0;
                    rs_d    = '0;
                    imm_d   = '0;
                end else if (enter) begin
                    if (state_q == S_OP) begin
                        op_d    = sw[3:0];
                        state_d = S_RD;
                    end else if (state_q == S_RD) begin
                        rd_d    = sw[3:0];
                        state_d = S_SRC;
                    end else begin
                        if (op_q == LD_OPCODE) imm_d = sw;
                        else                   rs_d  = sw[3:0];
                        instr_d = word_c;
                        valid_d = 1'b1;
                        state_d = S_SEND;
                    end
                end
            end
            S_SEND: begin
                // Valid is held until accepted; clear and enter are ignored
                valid_d = 1'b1;
                if (instr_ready) begin
                    valid_d = 1'b0;
                    if (wr_addr == '1) begin
                        full_d  = 1'b1;
                        state_d = S_FULL;
                    end else begin
                        addr_d  = wr_addr + ADDR_W'(1);
                        state_d = S_OP;
                    end
                end
            end
            S_FULL: begin
                if (clear) begin
                    addr_d  = '0;
                    full_d  = 1'b0;
                    state_d = S_OP;
                end
            end
            default: state_d = S_OP;
        endcase
        step_d = step_of(state_d);
    end

    // Registered datapath and outputs
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            op_q        <= '0;
            rd_q        <= '0;
            rs_q        <= '0;
            imm_q       <= '0;
            instr_out   <= '0;
            instr_valid <= 1'b0;
            wr_addr     <= '0;
            mem_full    <= 1'b0;
            step        <= '0;
        end else begin
            op_q        <= op_d;
            rd_q        <= rd_d;
            rs_q        <= rs_d;
            imm_q       <= imm_d;
            instr_out   <= instr_d;
            instr_valid <= valid_d;
            wr_addr     <= addr_d;
            mem_full    <= full_d;
            step        <= step_d;
        end
    end

endmodule

// File: doc/instr_encoder.md
# instr_encoder

Instruction-entry encoder: assembles 16-bit instruction words from board switches over successive `enter` presses and writes each finished word to instruction memory through a valid/ready handshake. It is the write-side counterpart of the instruction decoder. Every word it emits uses exactly the field layout the decoder splits apart, so anything this block programs decodes correctly downstream.

## Interface
- `ADDR_W`, 4, instruction-memory address width (depth 2^ADDR_W)
- `LD_OPCODE`, 4'b0001, opcode using immediate format
- `clk`  in  1  system clock, all logic on rising edge
- `rst_n`  in  1  asynchronous, active-low reset
- `sw`  in  8  switch field value
- `enter`  in  1  single-cycle pulse (already debounced), captures current field
- `clear`  in  1  single-cycle pulse, aborts entry / releases full
- `instr_out`  out  16  assembled instruction word
- `instr_valid`  out  1  `instr_out` and `wr_addr` valid for write
- `instr_ready`  in  1  memory accepts word this cycle
- `wr_addr`  out  ADDR_W  target address of current word
- `mem_full`  out  1  last address written; entry blocked
- `step`  out  2  current state encoding, drives LEDs

## Operation
- The state machine has five states: S_OP=0, S_RD=1, S_SRC=2, S_SEND=3, S_FULL. `step` shows S_FULL as 3.
- S_OP, on `enter`: latch `op` = `sw[3:0]`, then go to S_RD.
- S_RD, on `enter`: latch `rd` = `sw[3:0]`, then go to S_SRC. `sw[7:4]` is ignored.
- S_SRC, on `enter`:
  - If `op == LD_OPCODE`, latch `imm` = `sw[7:0]`.
  - Otherwise, latch `rs` = `sw[3:0]`.
  - Register `instr_out` and go to S_SEND.
- Word packing:
  - Immediate format: {op, rd, imm}.
  - Register format: {op, 4'h0, rd, rs}.
- S_SEND: `instr_valid`=1. On `instr_valid & instr_ready`:
  - If `wr_addr` == 2^ADDR_W−1, go to S_FULL with `mem_full`=1 and `wr_addr` held.
  - Otherwise, `wr_addr`+1 and go to S_OP.
- S_FULL: `enter` is ignored. `clear` sets `wr_addr`=0 and `mem_full`=0, then goes to S_OP.
- `clear` in S_OP, S_RD or S_SRC: go to S_OP and zero the latched fields. `wr_addr` is unchanged.
- `clear` in S_SEND is ignored, because a raised valid is never withdrawn.
- `enter` and `clear` in the same cycle: `clear` wins.
- `enter` in S_SEND is ignored.
- `wr_addr` never wraps silently. Address reuse happens only through `clear` from S_FULL.

## Timing
- Reset values: state S_OP; `instr_out`=16'h0000; `instr_valid`=0; `wr_addr`=0; `mem_full`=0; `step`=0; all internal fields 0.
- Reset takes effect immediately, mid-entry or mid-handshake. Any pending word is dropped.
- Latency: `instr_valid` rises on the clock edge after the `enter` sampled in S_SRC.
- While `instr_valid`=1, `instr_out` and `wr_addr` are stable until the handshake cycle.
- Handshake completes in the cycle where `instr_valid & instr_ready` is sampled high. `instr_valid` falls the next edge.
- Back-to-back words: at least 3 `enter` pulses apart. One word per 4 cycles is the minimum when `instr_ready` is tied high.
- `instr_ready` asserted while `instr_valid`=0 has no effect.
- All outputs are registered. There are no combinational paths from inputs to outputs.

## Structure
- Shared package `isa_pkg` holds:
  - Opcode constants, including `LD_OPCODE`.
  - Field bit positions: OP[15:12], RD_IMM[11:8], RD_REG[7:4], RS[3:0], IMM[7:0].
  - The state encoding.
- The decoder imports the same package, so the field layout is defined once.
- One natural sub-module, `instr_pack`: combinational {op, rd, rs, imm} → 16-bit word per `isa_pkg` layout. It is reusable in benches as a reference model.

## Test plan
- LD entry: enters of sw=0x01, 0x03, 0xA5 with ready high → `instr_out`=16'h13A5, `wr_addr`=0, valid for 1 cycle, then `wr_addr`=1.
- Register entry: enters of 0x02, 0xF4 (upper nibble ignored), 0x07 → `instr_out`=16'h2047.
- Backpressure: `instr_ready` low for 5 cycles after valid, with extra `enter` pulses → valid held, word and address stable, no state change; accepted on the first ready cycle.
- Clear: `clear` in S_SRC → `step`=0, no write. `clear`+`enter` same cycle in S_RD → S_OP. `clear` during S_SEND → ignored.
- Full: 16 words with ADDR_W=4 → after the 16th, `mem_full`=1 and `wr_addr`=15, `enter` ignored; `clear` → `wr_addr`=0, `mem_full`=0.
- Reset: `rst_n` low while `instr_valid`=1 and `instr_ready`=0 → all outputs at reset values immediately; no write on release.
